// File: rtl/alu_disp_pkg.sv
// Shared opcode and glyph definitions for the ALU result display.
package alu_disp_pkg;

  typedef enum logic [2:0] {
    FN_ADD = 3'd0,
    FN_SUB = 3'd1,
    FN_NOT = 3'd2,
    FN_AND = 3'd3,
    FN_OR  = 3'd4,
    FN_XOR = 3'd5,
    FN_LT  = 3'd6,
    FN_EQ  = 3'd7
  } func_e;

  localparam logic [4:0] GL_BLANK = 5'd16;
  localparam logic [4:0] GL_MINUS = 5'd17;
  localparam logic [4:0] GL_C     = 5'd18;
  localparam logic [4:0] GL_O     = 5'd19;

  localparam int NUM_DIGITS = 4;

endpackage

// File: rtl/seg7_decode.sv
// Glyph code to active-low {g,f,e,d,c,b,a} segment pattern.
module seg7_decode
  import alu_disp_pkg::*;
(
  input  logic [4:0] glyph,
  output logic [6:0] segs
);

  always_comb begin
    segs = 7'b1111111;
    case (glyph)
      5'd0:     segs = 7'b1000000;
      5'd1:     segs = 7'b1111001;
      5'd2:     segs = 7'b0100100;
      5'd3:     segs = 7'b0110000;
      5'd4:     segs = 7'b0011001;
      5'd5:     segs = 7'b0010010;
      5'd6:     segs = 7'b0000010;
      5'd7:     segs = 7'b1111000;
      5'd8:     segs = 7'b0000000;
      5'd9:     segs = 7'b0010000;
      5'd10:    segs = 7'b0001000;
      5'd11:    segs = 7'b0000011;
      5'd12:    segs = 7'b1000110;
      5'd13:    segs = 7'b0100001;
      5'd14:    segs = 7'b0000110;
      5'd15:    segs = 7'b0001110;
      GL_MINUS: segs = 7'b0111111;
      GL_C:     segs = 7'b1000110;
      GL_O:     segs = 7'b0100011;
      default:  segs = 7'b1111111;
    endcase
  end

endmodule

// File: rtl/alu_result_display.sv
// Captures an ALU result on a strobe and scans it onto a 4-digit common-anode
// 7-segment display; a held overflow makes the whole display blink.
module alu_result_display
  import alu_disp_pkg::*;
#(
  parameter int SCAN_DIV  = 50000,
  parameter int BLINK_DIV = 250
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cap_en,
  input  logic [2:0]            func,
  input  logic [3:0]            result,
  input  logic                  c,
  input  logic                  over,
  output logic [NUM_DIGITS-1:0] an,
  output logic [7:0]            seg
);

  localparam int SW    = $clog2(SCAN_DIV);
  localparam int BW    = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam int IDX_W = $clog2(NUM_DIGITS);

  localparam logic [SW-1:0] SCAN_LAST  = SW'(SCAN_DIV - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

  logic [2:0]            func_q, func_d;
  logic [3:0]            result_q, result_d;
  logic                  c_q, c_d;
  logic                  over_q, over_d;
  logic [SW-1:0]         scan_cnt_q, scan_cnt_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [BW-1:0]         blink_cnt_q, blink_cnt_d;
  logic                  blink_vis_q, blink_vis_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic [7:0]            seg_q, seg_d;

  logic                  tick;
  logic                  arith;
  logic                  dark;
  logic [4:0]            glyph;
  logic [6:0]            segs;

  always_comb begin
    func_d      = func_q;
    result_d    = result_q;
    c_d         = c_q;
    over_d      = over_q;
    scan_cnt_d  = scan_cnt_q + 1'b1;
    idx_d       = idx_q;
    blink_cnt_d = blink_cnt_q;
    blink_vis_d = blink_vis_q;

    tick = (scan_cnt_q == SCAN_LAST);
    if (tick) begin
      scan_cnt_d = '0;
      idx_d      = idx_q + 1'b1;
      if (blink_cnt_q == BLINK_LAST) begin
        blink_cnt_d = '0;
        blink_vis_d = ~blink_vis_q;
      end else begin
        blink_cnt_d = blink_cnt_q + 1'b1;
      end
    end

    // A capture restarts the blink phase, overriding any tick on the same edge.
    if (cap_en) begin
      func_d      = func;
      result_d    = result;
      c_d         = c;
      over_d      = over;
      blink_cnt_d = '0;
      blink_vis_d = 1'b1;
    end
  end

  // Glyph for the digit currently enabled, from the held result.
  always_comb begin
    arith = (func_q <= FN_SUB);
    glyph = GL_BLANK;
    case (idx_q)
      2'd0:    glyph = arith ? {2'b00, result_q[2:0]} : {1'b0, result_q};
      2'd1:    glyph = (arith && result_q[3]) ? GL_MINUS : GL_BLANK;
      2'd2:    glyph = over_q ? GL_O : (c_q ? GL_C : GL_BLANK);
      default: glyph = {2'b00, func_q};
    endcase
  end

  seg7_decode u_decode (
    .glyph (glyph),
    .segs  (segs)
  );

  always_comb begin
    dark = over_q && !blink_vis_q;
    if (dark) begin
      an_d  = '1;
      seg_d = 8'hFF;
    end else begin
      an_d  = ~(NUM_DIGITS'(1) << idx_q);
      seg_d = {1'b1, segs};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      func_q      <= '0;
      result_q    <= '0;
      c_q         <= 1'b0;
      over_q      <= 1'b0;
      scan_cnt_q  <= '0;
      idx_q       <= '0;
      blink_cnt_q <= '0;
      blink_vis_q <= 1'b1;
      an_q        <= '1;
      seg_q       <= 8'hFF;
    end else begin
      func_q      <= func_d;
      result_q    <= result_d;
      c_q         <= c_d;
      over_q      <= over_d;
      scan_cnt_q  <= scan_cnt_d;
      idx_q       <= idx_d;
      blink_cnt_q <= blink_cnt_d;
      blink_vis_q <= blink_vis_d;
      an_q        <= an_d;
      seg_q       <= seg_d;
    end
  end

  assign an  = an_q;
  assign seg = seg_q;

endmodule

// File: tb/tb_alu_result_display.sv
// Directed bench for alu_result_display with a fast scan (4) and blink (2) rate.
module tb_alu_result_display;

  logic       clk = 1'b0;
  logic       rst;
  logic       cap_en;
  logic [2:0] func;
  logic [3:0] result;
  logic       c;
  logic       over;
  logic [3:0] an;
  logic [7:0] seg;

  int total = 0;
  int bad   = 0;
  int j     = 0;

  alu_result_display #(
    .SCAN_DIV  (4),
    .BLINK_DIV (2)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .cap_en (cap_en),
    .func   (func),
    .result (result),
    .c      (c),
    .over   (over),
    .an     (an),
    .seg    (seg)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
    j++;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (an !== 4'b1111 || seg !== 8'hFF) begin
      bad++;
      $display("FAIL reset_hold an=%b seg=%h required an=1111 seg=ff", an, seg);
    end
    #2 rst = 1'b1;
    step();
    cap_en = 1'b1; func = 3'd3; result = 4'hA; c = 1'b1; over = 1'b0;
    step();
    cap_en = 1'b0;
    repeat (6) step();
    @(posedge clk);
    #3 rst = 1'b0;
    #1;
    total++;
    if (an !== 4'b1111) begin
      bad++;
      $display("FAIL reset_async_an actual=%b required=1111", an);
    end
    total++;
    if (seg !== 8'hFF) begin
      bad++;
      $display("FAIL reset_async_seg actual=%h required=ff", seg);
    end
    repeat (2) @(posedge clk);
    #3 rst = 1'b1;
    j = 0;
    step();
    total++;
    if (an !== 4'b1110) begin
      bad++;
      $display("FAIL release_an actual=%b required=1110", an);
    end
    total++;
    if (seg !== 8'hC0) begin
      bad++;
      $display("FAIL release_seg actual=%h required=c0", seg);
    end
  endtask

  task automatic test_free_run();
    logic [3:0] exp_an [16];
    exp_an = '{4'b1110, 4'b1110, 4'b1110,
               4'b1101, 4'b1101, 4'b1101, 4'b1101,
               4'b1011, 4'b1011, 4'b1011, 4'b1011,
               4'b0111, 4'b0111, 4'b0111, 4'b0111,
               4'b1110};
    for (int k = 0; k < 16; k++) begin
      step();
      total++;
      if (an !== exp_an[k]) begin
        bad++;
        $display("FAIL free_run_an cycle=%0d actual=%b required=%b", j, an, exp_an[k]);
      end
    end
  endtask

  task automatic test_capture_arith();
    logic [7:0] exp_seg [4];
    int d;
    exp_seg = '{8'hB0, 8'hBF, 8'hFF, 8'hC0};
    cap_en = 1'b1; func = 3'd0; result = 4'b1011; c = 1'b0; over = 1'b0;
    step();
    cap_en = 1'b0;
    for (int k = 0; k < 16; k++) begin
      step();
      d = ((j - 1) / 4) % 4;
      total++;
      if (an !== ~(4'b0001 << d) || seg !== exp_seg[d]) begin
        bad++;
        $display("FAIL arith_digit%0d cycle=%0d an=%b seg=%h required seg=%h", d, j, an, seg, exp_seg[d]);
      end
    end
  endtask

  task automatic test_capture_logic();
    logic [7:0] exp_seg [4];
    int d;
    exp_seg = '{8'h88, 8'hFF, 8'hC6, 8'hB0};
    cap_en = 1'b1; func = 3'd3; result = 4'hA; c = 1'b1; over = 1'b0;
    step();
    cap_en = 1'b0;
    for (int k = 0; k < 16; k++) begin
      step();
      d = ((j - 1) / 4) % 4;
      total++;
      if (an !== ~(4'b0001 << d) || seg !== exp_seg[d]) begin
        bad++;
        $display("FAIL logic_digit%0d cycle=%0d an=%b seg=%h required seg=%h", d, j, an, seg, exp_seg[d]);
      end
    end
  endtask

  task automatic test_blink();
    logic [7:0] exp_seg [4];
    logic [3:0] ea;
    logic [7:0] es;
    int d, cap, rel;
    exp_seg = '{8'h92, 8'hFF, 8'hA3, 8'hF9};
    cap_en = 1'b1; func = 3'd1; result = 4'b0101; c = 1'b1; over = 1'b1;
    step();
    cap_en = 1'b0;
    cap = j;
    for (int k = 0; k < 32; k++) begin
      step();
      rel = j - cap;
      d = ((j - 1) / 4) % 4;
      if ((rel >= 9 && rel <= 16) || rel >= 25) begin
        ea = 4'b1111; es = 8'hFF;
      end else begin
        ea = ~(4'b0001 << d); es = exp_seg[d];
      end
      total++;
      if (an !== ea || seg !== es) begin
        bad++;
        $display("FAIL blink rel=%0d an=%b seg=%h required an=%b seg=%h", rel, an, seg, ea, es);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_seg [4];
    logic [3:0] ea;
    logic [7:0] es;
    int d, cap, rel;
    exp_seg = '{8'h8E, 8'hFF, 8'hA3, 8'hF8};
    while (j < 95) step();
    cap_en = 1'b1; func = 3'd7; result = 4'hF; c = 1'b0; over = 1'b1;
    step();
    cap_en = 1'b0;
    cap = j;
    total++;
    if (an !== 4'b1111 || seg !== 8'hFF) begin
      bad++;
      $display("FAIL b2b_dark_before an=%b seg=%h required an=1111 seg=ff", an, seg);
    end
    for (int k = 0; k < 16; k++) begin
      step();
      rel = j - cap;
      d = ((j - 1) / 4) % 4;
      if (rel >= 9) begin
        ea = 4'b1111; es = 8'hFF;
      end else begin
        ea = ~(4'b0001 << d); es = exp_seg[d];
      end
      total++;
      if (an !== ea || seg !== es) begin
        bad++;
        $display("FAIL b2b rel=%0d an=%b seg=%h required an=%b seg=%h", rel, an, seg, ea, es);
      end
    end
  endtask

  initial begin
    rst = 1'b0; cap_en = 1'b0; func = 3'd0; result = 4'd0; c = 1'b0; over = 1'b0;
    test_reset();
    test_free_run();
    test_capture_arith();
    test_capture_logic();
    test_blink();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
